// File: rtl/stn_pkg.sv
// stn_pkg: shared state encoding and field widths for the station tracker
package stn_pkg;
    typedef enum logic [1:0] {IDLE, SEEK, ACK, ARRIVED} stn_state_t;
    localparam int STN_W = 6;
    localparam int ID_W = 8;
endpackage

// File: rtl/stn_dup_tmr.sv
// stn_dup_tmr: age of the last accepted station, flags a repeat read while it is still fresh
module stn_dup_tmr
    import stn_pkg::*;
#(
    parameter int DUP_TMO_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [STN_W-1:0] id,
    input  logic [STN_W-1:0] last_id,
    output logic             dup
);
    logic [DUP_TMO_W-1:0] tmr;
    // restart on every accepted ID, otherwise count up and stick at all-ones (stale)
    always_ff @(posedge clk) begin
        if (rst)
            tmr <= '1;
        else if (clr)
            tmr <= '0;
        else if (tmr != '1)
            tmr <= tmr + 1'b1;
    end
    assign dup = (id == last_id) && (tmr != '1);
endmodule

// File: rtl/station_tracker.sv
// station_tracker: acks barcode station IDs, counts stations and flags arrival (optional STN_DUP_FILT_EN)
module station_tracker
    import stn_pkg::*;
#(
    parameter int STN_CNT_W = 4,
    parameter int DUP_TMO_W = 22
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ID_vld,
    input  logic [ID_W-1:0]      ID,
    output logic                 clr_ID_vld,
    input  logic [STN_W-1:0]     dest,
    input  logic                 dest_ld,
    output logic [STN_W-1:0]     stn_id,
    output logic                 stn_new,
    output logic [STN_CNT_W-1:0] stn_cnt,
    output logic                 at_dest,
    output logic                 busy
);
    stn_state_t state, nxt, ret;
    logic [STN_W-1:0] dest_r;
    logic dup, accept;
    assign accept = (state == SEEK) && ID_vld && !dest_ld && (ID[7:6] == 2'b00) && !dup;
`ifdef STN_DUP_FILT_EN
    stn_dup_tmr #(.DUP_TMO_W(DUP_TMO_W)) u_dup (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .id     (ID[STN_W-1:0]),
        .last_id(stn_id),
        .dup    (dup)
    );
`else
    assign dup = 1'b0;
`endif
    // next state: dest_ld wins, ACK returns to IDLE or to SEEK/ARRIVED by match result
    always_comb begin
        nxt = state;
        if (dest_ld)
            nxt = SEEK;
        else if (state == ACK)
            nxt = (ret == IDLE) ? IDLE : (at_dest ? ARRIVED : SEEK);
        else if (ID_vld)
            nxt = ACK;
    end
    // state, destination and station bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ret     <= IDLE;
            dest_r  <= '0;
            stn_id  <= '0;
            stn_cnt <= '0;
            stn_new <= 1'b0;
            at_dest <= 1'b0;
        end else begin
            state   <= nxt;
            stn_new <= accept;
            if (nxt == ACK)
                ret <= state;
            if (dest_ld) begin
                dest_r  <= dest;
                stn_cnt <= '0;
                at_dest <= 1'b0;
            end else if (accept) begin
                stn_id  <= ID[STN_W-1:0];
                stn_cnt <= (stn_cnt != '1) ? stn_cnt + 1'b1 : stn_cnt;
                at_dest <= (ID[STN_W-1:0] == dest_r);
            end
        end
    end
    assign clr_ID_vld = (state == ACK);
    assign busy = (state == SEEK) || (state == ACK);
endmodule

// File: tb/tb_station_tracker.sv
// tb_station_tracker: directed scenarios plus random traffic checked against a transaction-level model
module tb_station_tracker;
    localparam int CW = 2;
    localparam int TW = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam int TMAX = (1 << TW) - 1;
    logic clk = 1'b0;
    logic rst, ID_vld, dest_ld;
    logic [7:0] ID;
    logic [5:0] dest;
    logic clr_ID_vld, stn_new, at_dest, busy;
    logic [5:0] stn_id;
    logic [CW-1:0] stn_cnt;
    int n_cmp = 0;
    int n_err = 0;
    bit m_ack, m_new, m_at;
    int m_mode, m_cnt, m_id, m_dst, m_age;

    station_tracker #(.STN_CNT_W(CW), .DUP_TMO_W(TW)) dut (
        .clk(clk), .rst(rst), .ID_vld(ID_vld), .ID(ID), .clr_ID_vld(clr_ID_vld),
        .dest(dest), .dest_ld(dest_ld), .stn_id(stn_id), .stn_new(stn_new),
        .stn_cnt(stn_cnt), .at_dest(at_dest), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_dup();
`ifdef STN_DUP_FILT_EN
        return (int'(ID[5:0]) == m_id) && (m_age < TMAX);
`else
        return 1'b0;
`endif
    endfunction

    // model mode: 0 idle, 1 seeking, 2 arrived; m_ack marks the one acknowledge cycle
    task automatic model_edge();
        bit acc;
        acc = 1'b0;
        m_new = 1'b0;
        if (rst) begin
            m_ack = 0; m_mode = 0; m_dst = 0; m_cnt = 0; m_id = 0; m_at = 0; m_age = TMAX;
            return;
        end
        if (dest_ld) begin
            m_dst = dest; m_cnt = 0; m_at = 0; m_mode = 1; m_ack = 0;
        end else if (m_ack) begin
            m_ack = 0;
        end else if (ID_vld) begin
            m_ack = 1;
            if (m_mode == 1 && ID[7:6] == 2'b00 && !is_dup()) begin
                acc = 1;
                m_id = ID[5:0];
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                m_new = 1;
                m_at = (m_id == m_dst);
                if (m_at) m_mode = 2;
            end
        end
        m_age = acc ? 0 : ((m_age < TMAX) ? m_age + 1 : TMAX);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("clr_ID_vld", clr_ID_vld, m_ack);
        chk("stn_new", stn_new, m_new);
        chk("stn_cnt", stn_cnt, m_cnt);
        chk("stn_id", stn_id, m_id);
        chk("at_dest", at_dest, m_at);
        chk("busy", busy, m_ack || m_mode == 1);
        if (clr_ID_vld) ID_vld = 1'b0;
    endtask

    task automatic load(input int d);
        dest = 6'(d); dest_ld = 1'b1;
        cyc();
        dest_ld = 1'b0;
    endtask

    task automatic send(input logic [7:0] id);
        ID = id; ID_vld = 1'b1;
        for (int k = 0; k < 10 && ID_vld; k++) cyc();
        if (ID_vld) begin
            chk("ack_timeout", 0, 1);
            ID_vld = 1'b0;
        end
        cyc();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        int r;
        rst = 1'b1; ID_vld = 1'b0; dest_ld = 1'b0; ID = '0; dest = '0;
        idle(2);
        rst = 1'b0;
        idle(2);
        load(5); send(8'h02); send(8'h03); send(8'h05); idle(2);
        load(5); send(8'h45); idle(1);
        dest = 6'h03; dest_ld = 1'b1; ID = 8'h03; ID_vld = 1'b1;
        cyc();
        dest_ld = 1'b0;
        idle(4);
        rst = 1'b1; idle(1); rst = 1'b0;
        send(8'h07);
        load(1); send(8'h01); send(8'h02); idle(1);
        load(9); send(8'h03); idle(100); send(8'h03); idle(260); send(8'h03);
        load(9); ID = 8'h04; ID_vld = 1'b1;
        cyc();
        rst = 1'b1; idle(1); rst = 1'b0; idle(1);
        load(60);
        for (int k = 0; k < 5; k++) send(8'(k + 10));
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            dest_ld = ($urandom_range(0, 19) == 0);
            dest = 6'($urandom_range(0, 7));
            if (!ID_vld && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 9);
                ID_vld = 1'b1;
                ID = (r < 2) ? {2'($urandom_range(1, 3)), 6'($urandom_range(0, 7))} :
                     (r < 4) ? {2'b00, 6'(m_id)} : 8'($urandom_range(0, 7));
            end
            cyc();
        end
        rst = 1'b0; dest_ld = 1'b0; ID_vld = 1'b0;
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
